adc_sample_store: RTL and testbench
===================================

Name: adc_sample_store

Overview:
- Consumer end of the timing FSM's store strobe. Captures one ADC sample per fastClk cycle while store_strb is high into an on-chip buffer, up to num_smpls samples.
- After capture, presents the buffer for an in-order, single-pass readout through a request/valid handshake, then re-arms for the next trigger.
- Sits between the ADC data path and the readout/transfer logic, in the fastClk domain.

Parameters:
DATA_W, 13, ADC sample width in bits.
ADDR_W, 10, buffer address width; depth = 2**ADDR_W = 1024 samples.

Ports:
fastClk  in  1  sampling clock; the only clock.
rst  in  1  synchronous, active-high reset.
store_strb  in  1  store strobe from the timing FSM; high for each sample to store.
adc_data  in  DATA_W  ADC sample, valid on every fastClk edge.
num_smpls  in  ADDR_W  requested samples per capture; sampled at capture start.
rd_en  in  1  readout request; one sample per cycle in which it is high.
rd_data  out  DATA_W  readout sample, valid when rd_valid is high.
rd_valid  out  1  one-cycle qualifier for rd_data.
data_ready  out  1  high when a capture is complete and unread samples remain.
smpl_count  out  ADDR_W  number of samples stored in the last capture.
overrun  out  1  sticky flag: a store_strb rising edge arrived while not IDLE.
state  out  2  current FSM state, for debug.

Behaviour:
- Reset is synchronous and active-high. When rst is high:
  - state = IDLE.
  - rd_data, rd_valid, data_ready, smpl_count, overrun and all pointers are cleared to 0.
  - Buffer contents are not cleared.
- store_strb_d is store_strb registered by one cycle. A capture starts on a rising edge: store_strb & ~store_strb_d.
- State encoding: IDLE=0, CAPTURE=1, READY=2, READOUT=3.
- IDLE:
  - On a rising edge with num_smpls != 0: write adc_data to address 0, set wr_ptr=1, latch num_smpls into n_lat, clear overrun.
  - If n_lat == 1, go to READY with smpl_count=1; otherwise go to CAPTURE.
  - On a rising edge with num_smpls == 0: stay in IDLE and write nothing.
  - rd_en is ignored in IDLE.
- CAPTURE:
  - Each cycle with store_strb=1: write adc_data at wr_ptr and increment wr_ptr.
  - When the write just made was at n_lat-1: go to READY with smpl_count=n_lat.
  - If store_strb=0 (strobe ended early): go to READY with smpl_count=wr_ptr. This is a truncated capture; nothing is written that cycle.
  - rd_en is ignored in CAPTURE.
- READY: data_ready=1 and rd_ptr=0.
  - rd_en: read mem[rd_ptr], increment rd_ptr, go to READOUT.
- READOUT:
  - data_ready stays 1 until the last read is issued.
  - Each cycle with rd_en=1 and rd_ptr < smpl_count: issue a read and increment rd_ptr.
  - Read latency is 1 cycle. rd_data and rd_valid are registered, so rd_valid is high in the cycle after each accepted rd_en.
  - rd_en=0 stalls the readout; no timeout.
  - When the read of address smpl_count-1 is issued: data_ready goes to 0 in the next cycle. The state returns to IDLE in that same cycle, coinciding with the final rd_valid.
  - Extra rd_en after the last read is ignored.
- A store_strb rising edge in CAPTURE (only possible after a gap, which already ended the capture), READY or READOUT: the samples are not written, overrun is set to 1, and the buffer is unaffected.
- A rising edge in the same cycle the FSM returns to IDLE is treated as overrun. The next capture requires a fresh rising edge.
- rd_data holds its last value when rd_valid=0.
- Reset during CAPTURE or READOUT aborts immediately. Partial data is discarded logically (smpl_count=0), and the next rising edge starts a fresh capture.
- Buffer: simple dual-port, 1 write and 1 read port, synchronous read, inferable as block RAM.

Test Plan:
- num_smpls=165; store_strb high for 165 cycles with a ramp adc_data=0..164; then rd_en held high -> data_ready=1 and smpl_count=165; 165 rd_valid pulses with rd_data=0..164 in order, first valid 1 cycle after the first rd_en; IDLE after the last.
- num_smpls=165; store_strb high for only 40 cycles -> smpl_count=40; readout returns 0..39; data_ready drops after the 40th read.
- num_smpls=0 with a store_strb pulse -> state stays 0; data_ready=0; no writes.
- Capture 10 samples, then a second store_strb pulse during READY -> overrun=1; readout still returns the original 10 samples; overrun clears on the next valid capture start.
- rd_en toggling 1,0,1,0 during readout -> rd_valid follows rd_en delayed by 1 cycle; no samples skipped or duplicated.
- rst asserted mid-capture (sample 50 of 165), released, then a new 20-sample capture -> all outputs 0 during rst; new readout returns exactly 20 fresh samples.

Source files
------------

// File: rtl/adc_sample_store.sv
// adc_sample_store: captures a burst of ADC samples on the timing FSM's store
// strobe into a 2**ADDR_W deep buffer, then hands the burst out once, in
// order, through an rd_en / rd_valid handshake before re-arming.
module adc_sample_store #(
    parameter int DATA_W = 13,
    parameter int ADDR_W = 10
) (
    input  logic              fastClk,
    input  logic              rst,
    input  logic              store_strb,
    input  logic [DATA_W-1:0] adc_data,
    input  logic [ADDR_W-1:0] num_smpls,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              data_ready,
    output logic [ADDR_W-1:0] smpl_count,
    output logic              overrun,
    output logic [1:0]        state
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        READY   = 2'd2,
        READOUT = 2'd3
    } state_t;

    state_t cur_st, nxt_st;

    // Sample buffer: one write port, one registered read port.
    logic [DATA_W-1:0] mem [0:DEPTH-1];

    logic              store_strb_d;
    logic              rise;
    logic [ADDR_W-1:0] wr_ptr, wr_ptr_nxt;
    logic [ADDR_W-1:0] rd_ptr, rd_ptr_nxt;
    logic [ADDR_W-1:0] n_lat, n_lat_nxt;
    logic [ADDR_W-1:0] cnt_nxt;
    logic              ovr_nxt;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic              rd_issue;
    logic [ADDR_W-1:0] rd_addr;

    assign rise  = store_strb & ~store_strb_d;
    assign state = cur_st;

    // Next-state, buffer write/read strobes and pointer updates.
    always_comb begin
        nxt_st     = cur_st;
        wr_en      = 1'b0;
        wr_addr    = wr_ptr;
        wr_ptr_nxt = wr_ptr;
        n_lat_nxt  = n_lat;
        cnt_nxt    = smpl_count;
        rd_issue   = 1'b0;
        rd_addr    = rd_ptr;
        rd_ptr_nxt = rd_ptr;
        ovr_nxt    = overrun;

        // Any new strobe edge while busy is dropped and flagged; this also
        // covers an edge landing in the cycle the readout returns to IDLE.
        if (rise && (cur_st != IDLE))
            ovr_nxt = 1'b1;

        case (cur_st)
            IDLE: begin
                // A zero-length request is a no-op: nothing written, no state change.
                if (rise && (num_smpls != '0)) begin
                    wr_en      = 1'b1;
                    wr_addr    = '0;
                    wr_ptr_nxt = ADDR_W'(1);
                    n_lat_nxt  = num_smpls;
                    ovr_nxt    = 1'b0;
                    if (num_smpls == ADDR_W'(1)) begin
                        nxt_st  = READY;
                        cnt_nxt = ADDR_W'(1);
                    end else begin
                        nxt_st  = CAPTURE;
                    end
                end
            end

            CAPTURE: begin
                if (store_strb) begin
                    wr_en      = 1'b1;
                    wr_addr    = wr_ptr;
                    wr_ptr_nxt = wr_ptr + ADDR_W'(1);
                    if (wr_ptr == n_lat - ADDR_W'(1)) begin
                        nxt_st  = READY;
                        cnt_nxt = n_lat;
                    end
                end else begin
                    // Strobe dropped early: keep what was stored so far.
                    nxt_st  = READY;
                    cnt_nxt = wr_ptr;
                end
            end

            READY: begin
                rd_ptr_nxt = '0;
                if (rd_en) begin
                    rd_issue   = 1'b1;
                    rd_addr    = '0;
                    rd_ptr_nxt = ADDR_W'(1);
                    // A one-sample burst is finished by its first read.
                    nxt_st     = (smpl_count == ADDR_W'(1)) ? IDLE : READOUT;
                end
            end

            READOUT: begin
                if (rd_en && (rd_ptr < smpl_count)) begin
                    rd_issue   = 1'b1;
                    rd_addr    = rd_ptr;
                    rd_ptr_nxt = rd_ptr + ADDR_W'(1);
                    if (rd_ptr == smpl_count - ADDR_W'(1))
                        nxt_st = IDLE;
                end
            end

            default: nxt_st = IDLE;
        endcase
    end

    // Control state, pointers and status flags.
    always_ff @(posedge fastClk) begin
        if (rst) begin
            cur_st       <= IDLE;
            store_strb_d <= 1'b0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            n_lat        <= '0;
            smpl_count   <= '0;
            overrun      <= 1'b0;
            data_ready   <= 1'b0;
            rd_valid     <= 1'b0;
        end else begin
            cur_st       <= nxt_st;
            store_strb_d <= store_strb;
            wr_ptr       <= wr_ptr_nxt;
            rd_ptr       <= rd_ptr_nxt;
            n_lat        <= n_lat_nxt;
            smpl_count   <= cnt_nxt;
            overrun      <= ovr_nxt;
            // data_ready tracks the state it is about to enter so it drops
            // together with the return to IDLE after the last read.
            data_ready   <= (nxt_st == READY) || (nxt_st == READOUT);
            rd_valid     <= rd_issue;
        end
    end

    // Buffer write port; contents survive reset.
    always_ff @(posedge fastClk) begin
        if (wr_en && !rst)
            mem[wr_addr] <= adc_data;
    end

    // Registered read port; output holds between reads.
    always_ff @(posedge fastClk) begin
        if (rst)
            rd_data <= '0;
        else if (rd_issue)
            rd_data <= mem[rd_addr];
    end

endmodule

// File: tb/tb_adc_sample_store.sv
// Randomized bench for adc_sample_store. The reference model is a queue of the
// samples a capture should keep (the first min(num_smpls, strobe length)),
// drained in order by accepted reads.
module tb_adc_sample_store;

    localparam int DATA_W = 13;
    localparam int ADDR_W = 10;

    logic              fastClk = 1'b0;
    logic              rst = 1'b1;
    logic              store_strb = 1'b0;
    logic [DATA_W-1:0] adc_data = '0;
    logic [ADDR_W-1:0] num_smpls = '0;
    logic              rd_en = 1'b0;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              data_ready;
    logic [ADDR_W-1:0] smpl_count;
    logic              overrun;
    logic [1:0]        state;

    adc_sample_store #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .fastClk(fastClk), .rst(rst), .store_strb(store_strb), .adc_data(adc_data),
        .num_smpls(num_smpls), .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
        .data_ready(data_ready), .smpl_count(smpl_count), .overrun(overrun), .state(state)
    );

    always #5 fastClk = ~fastClk;

    int n_chk  = 0;
    int n_pass = 0;

    logic [DATA_W-1:0] exp_q[$];
    int                exp_cnt = 0;
    logic [DATA_W-1:0] last_rd = '0;
    bit                exp_ovr = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    endtask

    // Advance one clock; outputs are examined 1 time unit after the edge.
    task automatic tick();
        @(posedge fastClk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        chk("rst_state", state, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_ready", data_ready, 0);
        chk("rst_count", smpl_count, 0);
        chk("rst_ovr", overrun, 0);
        rst = 1'b0;
        store_strb = 1'b0;
        rd_en = 1'b0;
        tick();
        last_rd = '0;
        exp_ovr = 1'b0;
    endtask

    // Strobe high for len cycles with n requested; model keeps first min(n,len).
    task automatic capture(input int n, input int len, input bit ramp);
        exp_q.delete();
        num_smpls = ADDR_W'(n);
        for (int i = 0; i < len; i++) begin
            store_strb = 1'b1;
            adc_data   = ramp ? DATA_W'(i) : DATA_W'($urandom);
            if (i < n) exp_q.push_back(adc_data);
            tick();
            if (i == 0) begin
                exp_ovr = 1'b0;
                chk("ovr_clr", overrun, exp_ovr);
                // Request size only matters at capture start.
                num_smpls = ADDR_W'($urandom);
            end
        end
        store_strb = 1'b0;
        adc_data   = DATA_W'($urandom);
        tick();
        exp_cnt = exp_q.size();
        chk("cap_state", state, 2);
        chk("cap_ready", data_ready, 1);
        chk("cap_count", smpl_count, exp_cnt);
    endtask

    // mode 0: rd_en held, 1: toggling 1,0,1,0, 2: random.
    task automatic readout(input int mode, input bit strb_end);
        int issued = 0;
        int guard  = 0;
        bit acc;
        while (issued < exp_cnt && guard < 5000) begin
            case (mode)
                0:       rd_en = 1'b1;
                1:       rd_en = (guard % 2) == 0;
                default: rd_en = 1'($urandom_range(0, 1));
            endcase
            acc = rd_en && (issued < exp_cnt);
            if (strb_end && acc && issued == exp_cnt - 1) store_strb = 1'b1;
            tick();
            guard++;
            store_strb = 1'b0;
            chk("rd_valid", rd_valid, acc);
            if (acc) begin
                chk("rd_data", rd_data, exp_q[issued]);
                last_rd = exp_q[issued];
                issued++;
            end else begin
                chk("rd_hold", rd_data, last_rd);
            end
            chk("ro_ready", data_ready, issued < exp_cnt);
            chk("ro_state", state, (issued == 0) ? 2 : ((issued < exp_cnt) ? 3 : 0));
        end
        if (guard >= 5000) chk("ro_timeout", issued, exp_cnt);
        if (strb_end) exp_ovr = 1'b1;
        chk("ro_ovr", overrun, exp_ovr);
        rd_en = 1'b1;
        tick();
        chk("rd_extra", rd_valid, 0);
        chk("rd_extra_hold", rd_data, last_rd);
        chk("idle_after", state, 0);
        rd_en = 1'b0;
    endtask

    initial begin
        do_reset();

        // Full ramp capture, continuous readout.
        capture(165, 165, 1'b1);
        readout(0, 1'b0);

        // Truncated strobe.
        capture(165, 40, 1'b1);
        readout(0, 1'b0);

        // Zero-length request is ignored; rd_en in IDLE ignored.
        num_smpls = '0;
        for (int i = 0; i < 3; i++) begin
            store_strb = 1'b1;
            rd_en = 1'b1;
            tick();
            chk("n0_state", state, 0);
            chk("n0_ready", data_ready, 0);
            chk("n0_valid", rd_valid, 0);
        end
        store_strb = 1'b0;
        rd_en = 1'b0;
        tick();
        chk("n0_count", smpl_count, 40);

        // Strobe pulse while READY -> overrun, buffer intact.
        capture(10, 10, 1'b0);
        store_strb = 1'b1;
        adc_data = DATA_W'($urandom);
        tick();
        store_strb = 1'b0;
        tick();
        exp_ovr = 1'b1;
        chk("ovr_set", overrun, 1);
        chk("ovr_state", state, 2);
        chk("ovr_count", smpl_count, 10);
        readout(0, 1'b0);

        // Toggling rd_en; the capture also clears overrun.
        capture(12, 12, 1'b0);
        readout(1, 1'b0);

        // Edge boundaries: single-sample captures and strobe longer than request.
        capture(1, 1, 1'b0);
        readout(0, 1'b0);
        capture(1, 5, 1'b0);
        readout(2, 1'b0);
        capture(2, 1, 1'b0);
        readout(0, 1'b0);
        capture(6, 9, 1'b0);
        readout(2, 1'b1);

        // Random bursts with random rd_en, one with a strobe edge on the final read.
        for (int k = 0; k < 6; k++) begin
            capture($urandom_range(1, 200), $urandom_range(1, 220), 1'b0);
            readout(2, k == 2);
        end

        // Reset in the middle of a capture, then a fresh 20-sample capture.
        num_smpls = ADDR_W'(165);
        for (int i = 0; i < 50; i++) begin
            store_strb = 1'b1;
            adc_data = DATA_W'($urandom);
            tick();
        end
        do_reset();
        capture(20, 20, 1'b0);
        readout(0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
